// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg : shared constants and types for the execute stage
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package ex_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage : ex_pkg

`default_nettype wire

// File: rtl/ex_mul_iter.sv
// ---------------------------------------------------------------------------
// mul_iter : 32-cycle shift-add multiplier (low 32 bits of the product)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mul_iter
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  mul_state_t  r_state;
  mul_state_t  w_next;
  logic [4:0]  r_count;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        busy = start;
        if (start) w_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (r_count == 5'd31) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operands are captured only on the IDLE->BUSY transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= 5'd0;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_acc    <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= 32'd0;
            r_count  <= 5'd0;
          end
        end
        BUSY: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign product = r_acc;

endmodule : mul_iter

`default_nettype wire

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage : RV32 execute stage + EX/MEM register; EX_MUL_EN adds iterative MUL
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ex_stage
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_e,
  input  logic [31:0] rd1_e,
  input  logic [31:0] rd2_e,
  input  logic [31:0] immext_e,
  input  logic [4:0]  rd_e,
  input  logic [2:0]  alucontrol_e,
  input  logic        alusrc_e,
  input  logic        regwrite_e,
  input  logic        memwrite_e,
  input  logic [1:0]  resultsrc_e,
  input  logic        mul_e,
  input  logic [1:0]  forwarda_e,
  input  logic [1:0]  forwardb_e,
  input  logic [31:0] result_w,
  output logic        stall_e,
  output logic        zero_e,
  output logic [31:0] aluresult_m,
  output logic [31:0] writedata_m,
  output logic [31:0] pc_m,
  output logic [4:0]  rd_m,
  output logic        regwrite_m,
  output logic        memwrite_m,
  output logic [1:0]  resultsrc_m
);

  logic [31:0] w_srca;
  logic [31:0] w_fwdb;
  logic [31:0] w_srcb;
  logic [31:0] w_alu;
  logic        w_stall;
  logic        w_done;
  logic [31:0] w_product;

  always_comb begin
    case (forwarda_e)
      FWD_WB:  w_srca = result_w;
      FWD_MEM: w_srca = aluresult_m;
      default: w_srca = rd1_e;
    endcase
    case (forwardb_e)
      FWD_WB:  w_fwdb = result_w;
      FWD_MEM: w_fwdb = aluresult_m;
      default: w_fwdb = rd2_e;
    endcase
  end

  assign w_srcb = alusrc_e ? immext_e : w_fwdb;

  always_comb begin
    case (alucontrol_e)
      ALU_ADD: w_alu = w_srca + w_srcb;
      ALU_SUB: w_alu = w_srca - w_srcb;
      ALU_AND: w_alu = w_srca & w_srcb;
      ALU_OR:  w_alu = w_srca | w_srcb;
      ALU_SLT: w_alu = {31'd0, $signed(w_srca) < $signed(w_srcb)};
      default: w_alu = 32'd0;
    endcase
  end

  assign zero_e = (w_alu == 32'd0);

`ifdef EX_MUL_EN
  mul_iter u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_e),
    .a       (w_srca),
    .b       (w_srcb),
    .busy    (w_stall),
    .done    (w_done),
    .product (w_product)
  );
`else
  logic w_unused;
  assign w_unused  = mul_e;
  assign w_stall   = 1'b0;
  assign w_done    = 1'b0;
  assign w_product = 32'd0;
`endif

  assign stall_e = w_stall;

  // A stalled cycle loads an all-zero bubble toward MEM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aluresult_m <= 32'd0;
      writedata_m <= 32'd0;
      pc_m        <= 32'd0;
      rd_m        <= 5'd0;
      regwrite_m  <= 1'b0;
      memwrite_m  <= 1'b0;
      resultsrc_m <= 2'd0;
    end else if (w_stall) begin
      aluresult_m <= 32'd0;
      writedata_m <= 32'd0;
      pc_m        <= 32'd0;
      rd_m        <= 5'd0;
      regwrite_m  <= 1'b0;
      memwrite_m  <= 1'b0;
      resultsrc_m <= 2'd0;
    end else begin
      aluresult_m <= w_done ? w_product : w_alu;
      writedata_m <= w_fwdb;
      pc_m        <= pc_e;
      rd_m        <= rd_e;
      regwrite_m  <= regwrite_e;
      memwrite_m  <= memwrite_e;
      resultsrc_m <= resultsrc_e;
    end
  end

endmodule : ex_stage

`default_nettype wire
